// File: rtl/mmio_fifo_pkg.sv
// Register offsets, STATUS/CTRL bit positions and the STATUS packing helper
// shared by the MMIO FIFO bank and its bench.
package mmio_fifo_pkg;

  localparam logic [15:0] DATA_OFS   = 16'd0;
  localparam logic [15:0] STATUS_OFS = 16'd2;
  localparam logic [15:0] CTRL_OFS   = 16'd4;
  localparam logic [15:0] PEEK_OFS   = 16'd6;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_OVF_BIT   = 18;
  localparam int ST_UNF_BIT   = 19;
  localparam int ST_DEPTH_LSB = 32;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_PEEK
  } reg_sel_e;

  function automatic logic [63:0] pack_status(
    input logic [15:0] count,
    input logic        empty,
    input logic        full,
    input logic        ovf,
    input logic        unf,
    input logic [15:0] depth
  );
    logic [63:0] s;
    s = '0;
    s[ST_COUNT_LSB +: 16] = count;
    s[ST_EMPTY_BIT]       = empty;
    s[ST_FULL_BIT]        = full;
    s[ST_OVF_BIT]         = ovf;
    s[ST_UNF_BIT]         = unf;
    s[ST_DEPTH_LSB +: 16] = depth;
    return s;
  endfunction

endpackage

// File: rtl/mmio_fifo_store.sv
// Circular buffer with push/pop/flush; head is a combinational read of the oldest entry.
// No backpressure: the caller must never push when full unless it pops in the same cycle.
module mmio_fifo_store
  import mmio_fifo_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_fifo_bank.sv
// MMIO-mapped FIFO with DATA/STATUS/CTRL registers (+PEEK when MMIO_FIFO_PEEK_EN is defined).
// Read responses arrive exactly one cycle after the read; no backpressure, full/empty drop with sticky ovf/unf.
module mmio_fifo_bank
  import mmio_fifo_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [63:0] mmio_wr_data,
  input  logic [8:0]  mmio_tid,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        full,
  output logic        empty
);

  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [15:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
  localparam logic [15:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;
  localparam logic [15:0] PEEK_ADDR   = BASE_ADDR + PEEK_OFS;
  localparam logic [15:0] DEPTH16     = 16'(DEPTH);

  reg_sel_e          sel;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic [63:0]       head_ext;
  logic [63:0]       rd_value;
  logic              wr_data, rd_data, ctrl_wr;
  logic              push, pop, flush, clear;
  logic              rd_mapped;
  logic              ovf, unf;

  always_comb begin
    sel = REG_NONE;
    if (mmio_addr == DATA_ADDR)        sel = REG_DATA;
    else if (mmio_addr == STATUS_ADDR) sel = REG_STATUS;
    else if (mmio_addr == CTRL_ADDR)   sel = REG_CTRL;
`ifdef MMIO_FIFO_PEEK_EN
    else if (mmio_addr == PEEK_ADDR)   sel = REG_PEEK;
`endif
  end

  assign wr_data   = mmio_wr_valid && (sel == REG_DATA);
  assign rd_data   = mmio_rd_valid && (sel == REG_DATA);
  assign ctrl_wr   = mmio_wr_valid && (sel == REG_CTRL);
  assign rd_mapped = mmio_rd_valid && (sel != REG_NONE);

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign pop   = rd_data && !empty;
  assign push  = wr_data && (!full || pop);
  assign flush = ctrl_wr && mmio_wr_data[CTRL_FLUSH_BIT];
  assign clear = ctrl_wr && mmio_wr_data[CTRL_CLEAR_BIT];

  mmio_fifo_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (mmio_wr_data[DATA_W-1:0]),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    head_ext = '0;
    head_ext[DATA_W-1:0] = head;
  end

  always_comb begin
    rd_value = '0;
    case (sel)
      REG_DATA, REG_PEEK: rd_value = empty ? 64'd0 : head_ext;
      REG_STATUS: rd_value = pack_status(16'(count), empty, full, ovf, unf, DEPTH16);
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (clear) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (wr_data && full && !pop) ovf <= 1'b1;
      if (rd_data && empty)        unf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rd_mapped;
      if (rd_mapped) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Bench for mmio_fifo_bank: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_mmio_fifo_bank;

  localparam int          DW   = 48;
  localparam int          DEP  = 4;
  localparam logic [15:0] BASE = 16'h0020;
  localparam logic [63:0] DMASK = (64'd1 << DW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [63:0] mmio_wr_data = '0;
  logic [8:0]  mmio_tid = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  mmio_fifo_bank #(
    .DATA_W    (DW),
    .DEPTH     (DEP),
    .BASE_ADDR (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_wr_data  (mmio_wr_data),
    .mmio_tid      (mmio_tid),
    .rsp_valid     (rsp_valid),
    .rsp_tid       (rsp_tid),
    .rsp_data      (rsp_data),
    .full          (full),
    .empty         (empty)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as a queue plus the two sticky flags.
  logic [63:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [63:0] wd;
    logic [8:0]  tid;
    logic        ev;
    logic [63:0] ed;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic [15:0] addr,
                      input logic [63:0] wd, input logic [8:0] tid);
    @(negedge clk);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_wr_data  = wd;
    mmio_tid      = tid;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic wr, input logic rd, input logic [15:0] addr,
                     input logic [63:0] wd, input logic [8:0] tid,
                     input logic ev, input logic [63:0] ed);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.tid = tid; v.ev = ev; v.ed = ed;
    vt.push_back(v);
  endtask

  function automatic logic [63:0] status_of(input int n, input logic o, input logic u);
    logic [63:0] s;
    s = 64'(DEP) << 32;
    s = s | 64'(n);
    if (n == 0)   s = s | (64'd1 << 16);
    if (n == DEP) s = s | (64'd1 << 17);
    if (o)        s = s | (64'd1 << 18);
    if (u)        s = s | (64'd1 << 19);
    return s;
  endfunction

  task automatic model(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [63:0] wd, output logic ev, output logic [63:0] ed);
    int n;
    n  = q.size();
    ev = 1'b0;
    ed = 64'd0;
    if (rd) begin
      if (addr == BASE) begin
        ev = 1'b1; ed = (n > 0) ? q[0] : 64'd0;
      end else if (addr == BASE + 16'd2) begin
        ev = 1'b1; ed = status_of(n, m_ovf, m_unf);
      end else if (addr == BASE + 16'd4) begin
        ev = 1'b1;
`ifdef MMIO_FIFO_PEEK_EN
      end else if (addr == BASE + 16'd6) begin
        ev = 1'b1; ed = (n > 0) ? q[0] : 64'd0;
`endif
      end
    end
    if (rd && addr == BASE) begin
      if (n > 0) void'(q.pop_front());
      else       m_unf = 1'b1;
    end
    if (wr && addr == BASE) begin
      if (q.size() < DEP) q.push_back(wd & DMASK);
      else                m_ovf = 1'b1;
    end
    if (wr && addr == BASE + 16'd4) begin
      if (wd[0]) q.delete();
      if (wd[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end
  endtask

  initial begin
    logic        ev;
    logic [63:0] ed;
    logic        pk_ev;
    logic [63:0] pk_d;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_tid",   64'(rsp_tid),   64'd0);
    check("rst_rsp_data",  rsp_data,       64'd0);
    check("rst_empty",     64'(empty),     64'd1);
    check("rst_full",      64'(full),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: wr, rd, addr, wdata, tid, expected valid, expected data
    add(1, 0, 16'h20, 64'hA, 0, 0, 0);
    add(1, 0, 16'h20, 64'hB, 0, 0, 0);
    add(1, 0, 16'h20, 64'hC, 0, 0, 0);
    add(0, 1, 16'h20, 0, 9'd1, 1, 64'hA);
    add(0, 1, 16'h20, 0, 9'd2, 1, 64'hB);
    add(0, 1, 16'h20, 0, 9'd3, 1, 64'hC);
    add(0, 1, 16'h20, 0, 9'd4, 1, 64'h0);
    add(0, 1, 16'h22, 0, 9'd5, 1, 64'h0000_0004_0009_0000);
    add(1, 0, 16'h24, 64'h2, 0, 0, 0);
    add(0, 1, 16'h22, 0, 9'd6, 1, 64'h0000_0004_0001_0000);
    add(1, 0, 16'h20, 64'h11, 0, 0, 0);
    add(1, 0, 16'h20, 64'h22, 0, 0, 0);
    add(1, 0, 16'h20, 64'h33, 0, 0, 0);
    add(1, 0, 16'h20, 64'h44, 0, 0, 0);
    add(1, 0, 16'h20, 64'h55, 0, 0, 0);
    add(0, 1, 16'h22, 0, 9'd7, 1, 64'h0000_0004_0006_0004);
    add(0, 1, 16'h20, 0, 9'd8, 1, 64'h11);
    add(0, 1, 16'h20, 0, 9'd9, 1, 64'h22);
    add(0, 1, 16'h20, 0, 9'd10, 1, 64'h33);
    add(0, 1, 16'h20, 0, 9'd11, 1, 64'h44);
    add(1, 0, 16'h24, 64'h3, 0, 0, 0);
    add(1, 0, 16'h20, 64'h1, 0, 0, 0);
    add(1, 0, 16'h20, 64'h2, 0, 0, 0);
    add(1, 0, 16'h24, 64'h1, 0, 0, 0);
    add(0, 1, 16'h22, 0, 9'd12, 1, 64'h0000_0004_0001_0000);
    add(0, 1, 16'h30, 0, 9'd13, 0, 0);
    add(1, 0, 16'h30, 64'h99, 0, 0, 0);
    add(0, 1, 16'h22, 0, 9'd14, 1, 64'h0000_0004_0001_0000);
    add(1, 0, 16'h20, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    add(0, 1, 16'h20, 0, 9'd15, 1, 64'h0000_FFFF_FFFF_FFFF);
    add(1, 1, 16'h20, 64'h77, 9'd20, 1, 64'h0);
    add(0, 1, 16'h22, 0, 9'd21, 1, 64'h0000_0004_0008_0001);
    add(1, 0, 16'h24, 64'h3, 0, 0, 0);
    add(0, 1, 16'h24, 0, 9'd22, 1, 64'h0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wd, vt[i].tid);
      check($sformatf("vec%0d_valid", i), 64'(rsp_valid), 64'(vt[i].ev));
      if (vt[i].ev) begin
        check($sformatf("vec%0d_tid", i),  64'(rsp_tid), 64'(vt[i].tid));
        check($sformatf("vec%0d_data", i), rsp_data, vt[i].ed);
      end
    end
    step(0, 0, 16'h0, 0, 0);
    check("tbl_end_empty", 64'(empty), 64'd1);

    // PEEK: two reads of +6 must not consume the entry
`ifdef MMIO_FIFO_PEEK_EN
    pk_ev = 1'b1; pk_d = 64'h55;
`else
    pk_ev = 1'b0; pk_d = 64'h0;
`endif
    step(1, 0, 16'h20, 64'h55, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 16'h26, 0, 9'(30 + k));
      check($sformatf("peek%0d_valid", k), 64'(rsp_valid), 64'(pk_ev));
      if (pk_ev) begin
        check($sformatf("peek%0d_tid", k),  64'(rsp_tid), 64'(30 + k));
        check($sformatf("peek%0d_data", k), rsp_data, pk_d);
      end
    end
    step(0, 1, 16'h22, 0, 9'd32);
    check("peek_status", rsp_data, 64'h0000_0004_0000_0001);

    // Reset asserted while a response is showing discards it
    step(0, 1, 16'h20, 0, 9'd40);
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    check("pre_rst_data",  rsp_data,       64'h55);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_data",  rsp_data,       64'd0);
    check("mid_rst_tid",   64'(rsp_tid),   64'd0);
    check("mid_rst_empty", 64'(empty),     64'd1);
    step(0, 0, 16'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;

    // Random traffic against the queue model
    for (int c = 0; c < 800; c++) begin
      logic        wr, rd;
      logic [15:0] addr;
      logic [63:0] wd;
      logic [8:0]  tid;
      int          r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      addr = BASE;
      else if (r < 75) addr = BASE + 16'd2;
      else if (r < 82) addr = BASE + 16'd4;
      else if (r < 90) addr = BASE + 16'd6;
      else if (r < 95) addr = BASE + 16'd1;
      else             addr = 16'h0030;
      wr  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      tid = 9'($urandom_range(0, 511));
      if (addr == BASE + 16'd4) wd[0] = ($urandom_range(0, 3) == 0);
      model(wr, rd, addr, wd, ev, ed);
      step(wr, rd, addr, wd, tid);
      check($sformatf("rnd%0d_valid", c), 64'(rsp_valid), 64'(ev));
      if (ev) begin
        check($sformatf("rnd%0d_tid", c),  64'(rsp_tid), 64'(tid));
        check($sformatf("rnd%0d_data", c), rsp_data, ed);
      end
      check($sformatf("rnd%0d_full", c),  64'(full),  64'(q.size() == DEP));
      check($sformatf("rnd%0d_empty", c), 64'(empty), 64'(q.size() == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_bank.md
MMIO_FIFO_BANK -- requirements
Module: mmio_fifo_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning FIFO entry width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, meaning entry count (power of two, 2..1024).
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0020, meaning MMIO word address of the data register.
REQ-004 SHALL have port clk, input, 1, meaning the single clock. All logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port mmio_wr_valid, input, 1, meaning a decoded MMIO write is present this cycle.
REQ-007 SHALL have port mmio_rd_valid, input, 1, meaning a decoded MMIO read is present this cycle.
REQ-008 SHALL have port mmio_addr, input, 16, meaning the MMIO word address.
REQ-009 SHALL have port mmio_wr_data, input, 64, meaning the write payload.
REQ-010 SHALL have port mmio_tid, input, 9, meaning the read transaction ID.
REQ-011 SHALL have port rsp_valid, output, 1, meaning a read response is present this cycle.
REQ-012 SHALL have port rsp_tid, output, 9, meaning the TID echoed from the read.
REQ-013 SHALL have port rsp_data, output, 64, meaning the read response data.
REQ-014 SHALL have ports full and empty, output, 1 each, meaning live FIFO state.

Function
REQ-015 SHALL decode this register map, all offsets relative to BASE_ADDR:
- +0 DATA: a write pushes; a read pops.
- +2 STATUS: read-only.
- +4 CTRL: write-only.
REQ-016 SHALL make a write to DATA push mmio_wr_data[DATA_W-1:0] when not full.
REQ-017 SHALL, on a write to DATA while full, drop the data and set sticky ovf.
REQ-018 SHALL make a read of DATA return the head entry zero-extended to 64 bits and pop it.
REQ-019 SHALL make a read of DATA while empty return 0 and set sticky unf.
REQ-020 SHALL lay out STATUS as follows:
- [15:0] count
- [16] empty
- [17] full
- [18] ovf
- [19] unf
- [47:32] DEPTH
- other bits 0
REQ-021 SHALL act on CTRL writes as follows:
- bit0=1: flush the FIFO (pointers and count to 0).
- bit1=1: clear ovf and unf.
- Both bits set in one write perform both actions.
REQ-022 SHALL respond to a read of any mapped address in the next cycle: rsp_valid=1 for exactly one cycle, with rsp_tid and rsp_data.
REQ-023 SHALL never assert rsp_valid for unmapped addresses, and SHALL ignore writes to unmapped addresses.
REQ-024 SHALL, when a pushing write and a popping read arrive in the same cycle, perform both; count is unchanged, even when full.
- If that happens while empty: the push succeeds, the read returns 0 and sets unf.
REQ-025 SHALL, when a CTRL flush and a DATA read arrive in the same cycle, return the pre-flush head; the FIFO is empty afterwards.
REQ-026 SHALL wrap the read and write pointers modulo DEPTH, and keep count width at clog2(DEPTH)+1.
REQ-027 SHALL drive full and empty combinationally from count.

Reset
REQ-028 SHALL, while rst_n=0, hold rsp_valid=0, rsp_tid=0, rsp_data=0, pointers=0, count=0, ovf=0, unf=0, empty=1 and full=0.
REQ-029 SHALL discard any response pending when reset asserts mid-operation; storage contents are don't-care.

Configuration
REQ-030 SHALL, with MMIO_FIFO_PEEK_EN defined, map +6 PEEK: a read returns the head zero-extended without popping and never sets unf; returns 0 when empty.
REQ-031 SHALL, without MMIO_FIFO_PEEK_EN, leave +6 unmapped, with no response.

Structure
REQ-032 SHALL place in package mmio_fifo_pkg:
- offsets DATA_OFS, STATUS_OFS, CTRL_OFS and PEEK_OFS
- STATUS bit-position constants
- CTRL bit-position constants
REQ-033 SHALL instantiate one sub-module, mmio_fifo_store: a parametrised circular buffer with push/pop, head, count, full and empty outputs. Address decode and the response register stay in mmio_fifo_bank.

Verification
REQ-034 SHALL cover: push 0xA, 0xB, 0xC to 0x20, then read 0x20 three times -> responses 0xA, 0xB, 0xC, one cycle after each read, with matching TIDs.
REQ-035 SHALL cover: DEPTH=4, push 5 words -> STATUS reads count=4, full=1, ovf=1; pops return the first 4 words.
REQ-036 SHALL cover: read 0x20 when empty -> rsp_data=0 and unf=1; then CTRL write 0x2 -> STATUS bits[19:18]=0.
REQ-037 SHALL cover: DEPTH=4, push 6 and pop 6 interleaved across pointer wrap -> data order preserved, empty=1 at the end.
REQ-038 SHALL cover: push 2 words, CTRL write 0x1 -> STATUS count=0, empty=1; read of 0x30 -> no rsp_valid.
REQ-039 SHALL cover: with MMIO_FIFO_PEEK_EN, push 0x55 and read 0x26 twice -> 0x55 both times, count stays 1; without the macro -> no response.
